// File: rtl/gpi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gpi_pkg
//  Description : Shared constants for the GPI edge-capture slot: register
//                addresses within the slot and the per-bit edge-select
//                encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package gpi_pkg;

    // Register addresses within the slot (addr[4:0])
    localparam logic [4:0] GPI_STATE = 5'd0;
    localparam logic [4:0] GPI_CAP   = 5'd1;
    localparam logic [4:0] GPI_IEN   = 5'd2;
    localparam logic [4:0] GPI_EDGE  = 5'd3;

    // Per-bit edge select encoding held in the EDGE register
    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

endpackage : gpi_pkg
`default_nettype wire

// File: rtl/gpi_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : gpi_debounce
//  Description : One input bit: 2-FF synchroniser, persistence counter that
//                only accepts a new level after DB_CYCLES consecutive cycles,
//                and a delayed copy of the accepted level for edge detection.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpi_debounce
    import gpi_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,      // asynchronous, active-low
    input  logic i_pin,
    output logic o_stable,
    output logic o_rise,
    output logic o_fall
);

    localparam int             c_CW       = $clog2(DB_CYCLES + 1);
    localparam logic [c_CW-1:0] c_CNT_LAST = c_CW'(DB_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic            r_stable_d;
    logic [c_CW-1:0] r_cnt;

    // Two-stage synchroniser for the asynchronous pin
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only once it has differed for DB_CYCLES cycles;
    // any return to the accepted level restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_LAST) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + c_CW'(1);
        end
    end

    // Previous accepted level, used to form one-cycle edge pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stable_d <= 1'b0;
        end else begin
            r_stable_d <= r_stable;
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = r_stable & ~r_stable_d;
    assign o_fall   = ~r_stable & r_stable_d;

endmodule : gpi_debounce
`default_nettype wire

// File: rtl/gpi_edge.sv
`default_nettype none
// ============================================================================
//  Module      : gpi_edge
//  Description : General-purpose input slot. Synchronises and debounces W
//                pins, captures selected edges into a sticky W1C register and
//                raises a level interrupt for any enabled captured edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module gpi_edge
    import gpi_pkg::*;
#(
    parameter int W         = 8,
    parameter int DB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         reset,      // asynchronous, active-low
    input  logic         cs,
    input  logic         read,
    input  logic         write,
    input  logic [4:0]   addr,
    input  logic [31:0]  wr_data,
    output logic [31:0]  rd_data,
    input  logic [W-1:0] data_in,
    output logic         irq
);

    logic [W-1:0] w_stable;
    logic [W-1:0] w_rise;
    logic [W-1:0] w_fall;
    logic [W-1:0] w_hit;

    logic [W-1:0] r_cap;
    logic [W-1:0] r_ien;
    logic [W-1:0] r_edge;
    logic         r_irq;

    logic [W-1:0] w_cap_next;
    logic [W-1:0] w_ien_next;
    logic         w_wr_cap;
    logic         w_wr_ien;
    logic         w_wr_edge;

    // Reads have no side effects, and only the low W write bits matter
    logic w_unused;
    assign w_unused = ^{read, wr_data};

    // One synchroniser/debouncer per pin; edge select picks the hit polarity
    for (genvar i = 0; i < W; i++) begin : g_bit
        gpi_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk      (clk),
            .reset    (reset),
            .i_pin    (data_in[i]),
            .o_stable (w_stable[i]),
            .o_rise   (w_rise[i]),
            .o_fall   (w_fall[i])
        );
        assign w_hit[i] = (r_edge[i] == EDGE_FALL) ? w_fall[i] : w_rise[i];
    end

    assign w_wr_cap  = cs && write && (addr == GPI_CAP);
    assign w_wr_ien  = cs && write && (addr == GPI_IEN);
    assign w_wr_edge = cs && write && (addr == GPI_EDGE);

    // New hits are OR'd in after the clear so a coincident edge is never lost
    assign w_cap_next = (r_cap & ~(w_wr_cap ? wr_data[W-1:0] : '0)) | w_hit;
    assign w_ien_next = w_wr_ien ? wr_data[W-1:0] : r_ien;

    // Capture, enable and edge-select registers plus the registered irq
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cap  <= '0;
            r_ien  <= '0;
            r_edge <= '0;
            r_irq  <= 1'b0;
        end else begin
            r_cap <= w_cap_next;
            r_ien <= w_ien_next;
            r_irq <= |(w_cap_next & w_ien_next);
            if (w_wr_edge) begin
                r_edge <= wr_data[W-1:0];
            end
        end
    end

    // Combinational read mux; unmapped addresses read as zero
    always_comb begin
        rd_data = '0;
        case (addr)
            GPI_STATE: rd_data[W-1:0] = w_stable;
            GPI_CAP:   rd_data[W-1:0] = r_cap;
            GPI_IEN:   rd_data[W-1:0] = r_ien;
            GPI_EDGE:  rd_data[W-1:0] = r_edge;
            default:   rd_data = '0;
        endcase
    end

    assign irq = r_irq;

endmodule : gpi_edge
`default_nettype wire

// File: tb/tb_gpi_edge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gpi_edge
//  Description : Self-checking bench for gpi_edge (W=8, DB_CYCLES=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gpi_edge;

    localparam int W  = 8;
    localparam int DB = 4;

    logic         clk;
    logic         reset;
    logic         cs;
    logic         read;
    logic         write;
    logic [4:0]   addr;
    logic [31:0]  wr_data;
    logic [31:0]  rd_data;
    logic [W-1:0] data_in;
    logic         irq;

    int n_checks;
    int n_errors;

    gpi_edge #(
        .W         (W),
        .DB_CYCLES (DB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .read    (read),
        .write   (write),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_data (rd_data),
        .data_in (data_in),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        cs;
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [4:0]  raddr;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } bus_vec_t;

    bus_vec_t vecs [10];

    // Advance one clock and land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic read_check(input string name, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check32(name, rd_data, exp);
    endtask

    task automatic irq_check(input string name, input logic exp);
        check32(name, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        cs      = 1'b1;
        write   = 1'b1;
        addr    = a;
        wr_data = d;
        tick();
        cs      = 1'b0;
        write   = 1'b0;
        wr_data = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cs = 0; read = 0; write = 0; addr = '0; wr_data = '0; data_in = '0;
        reset = 1'b0;

        vecs[0] = '{1'b1, 1'b1, 5'd2, 32'h0000_003C, 5'd2, 32'h0000_003C, 1'b0};
        vecs[1] = '{1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0000_0000, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF, 5'd2, 32'h0000_003C, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 5'd9, 32'hFFFF_FFFF, 5'd9, 32'h0000_0000, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 5'd2, 32'h0000_0000, 5'd2, 32'h0000_003C, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 5'd2, 32'h0000_0000, 5'd2, 32'h0000_003C, 1'b0};
        vecs[6] = '{1'b1, 1'b1, 5'd3, 32'hFFFF_FF01, 5'd3, 32'h0000_0001, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 5'd2, 32'hFFFF_FF80, 5'd2, 32'h0000_0080, 1'b1};
        vecs[8] = '{1'b1, 1'b1, 5'd1, 32'h0000_007F, 5'd1, 32'h0000_0080, 1'b1};
        vecs[9] = '{1'b1, 1'b1, 5'd1, 32'hFFFF_FFFF, 5'd1, 32'h0000_0000, 1'b0};

        // ---------------- reset ----------------
        repeat (3) tick();
        reset = 1'b1;
        tick();
        for (int a = 0; a < 32; a++) begin
            read_check($sformatf("reset_rd_addr%0d", a), 5'(a), 32'h0);
        end
        irq_check("reset_irq", 1'b0);

        // ---------------- stable level, latency 2+DB ----------------
        addr    = 5'd0;
        data_in = 8'hA5;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 5) read_check("state_at_5", 5'd0, 32'h0);
            if (k == 6) begin
                read_check("state_at_6", 5'd0, 32'hA5);
                read_check("cap_at_6", 5'd1, 32'h0);
            end
            if (k == 7) read_check("cap_at_7", 5'd1, 32'hA5);
        end
        irq_check("irq_ien_zero", 1'b0);

        // Falling edges are ignored with EDGE=0; then clear everything
        data_in = 8'h00;
        repeat (8) tick();
        read_check("state_back_0", 5'd0, 32'h0);
        read_check("cap_no_fall", 5'd1, 32'hA5);
        bus_write(5'd1, 32'hFF);
        read_check("cap_cleared", 5'd1, 32'h0);

        // ---------------- debounce rejection: 3-clock pulse ----------------
        data_in = 8'h01;
        repeat (3) tick();
        data_in = 8'h00;
        repeat (10) tick();
        read_check("short_state", 5'd0, 32'h0);
        read_check("short_cap", 5'd1, 32'h0);

        // 4-clock pulse is accepted
        data_in = 8'h01;
        repeat (4) tick();
        data_in = 8'h00;
        repeat (2) tick();
        read_check("long_state", 5'd0, 32'h1);
        tick();
        read_check("long_cap", 5'd1, 32'h1);
        repeat (6) tick();
        read_check("long_state_gone", 5'd0, 32'h0);

        // ---------------- W1C and irq ----------------
        bus_write(5'd2, 32'h01);
        irq_check("irq_set", 1'b1);
        bus_write(5'd1, 32'h01);
        irq_check("irq_clr", 1'b0);
        read_check("cap_w1c", 5'd1, 32'h0);
        bus_write(5'd1, 32'h02);
        read_check("cap_w1c_nop", 5'd1, 32'h0);

        // ---------------- falling select ----------------
        bus_write(5'd3, 32'h80);
        data_in = 8'h80;
        repeat (10) tick();
        read_check("fall_no_rise", 5'd1, 32'h0);
        data_in = 8'h00;
        for (int k = 1; k <= 7; k++) begin
            tick();
            if (k == 6) read_check("fall_cap_6", 5'd1, 32'h0);
            if (k == 7) read_check("fall_cap_7", 5'd1, 32'h80);
        end
        bus_write(5'd1, 32'h80);
        read_check("fall_cap_clr", 5'd1, 32'h0);

        // ---------------- set/clear collision ----------------
        data_in = 8'h80;
        repeat (10) tick();
        data_in = 8'h00;
        repeat (6) tick();
        bus_write(5'd1, 32'h80);     // clear lands on the hit edge
        read_check("collision_cap", 5'd1, 32'h80);
        irq_check("collision_irq", 1'b0);

        // ---------------- bus hygiene table ----------------
        for (int i = 0; i < 10; i++) begin
            cs      = vecs[i].cs;
            write   = vecs[i].we;
            addr    = vecs[i].waddr;
            wr_data = vecs[i].wdata;
            tick();
            cs      = 1'b0;
            write   = 1'b0;
            wr_data = '0;
            read_check($sformatf("vec%0d_rd", i), vecs[i].raddr, vecs[i].exp_rd);
            irq_check($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_gpi_edge
`default_nettype wire
